hilo_ctrl: RTL and testbench

- Downstream consumer and sequencer for the iterative divider in the EX stage of the 5-stage CPU.
- Accepts DIVU and HI/LO instructions (MFHI, MFLO, MTHI, MTLO) from ID/EX.
- Drives the divider's 6-bit Signal and holds its operands stable for the full iteration.
- Captures the 64-bit {remainder, quotient} into HI/LO, serves MFHI/MFLO reads, and stalls the pipeline while a divide is in flight.

---
 rtl/hilo_ctrl_pkg.sv | 10 +
 rtl/hilo_ctrl_if.sv | 24 ++
 rtl/hilo_ctrl.sv | 78 +++++++
 tb/tb_hilo_ctrl.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/hilo_ctrl_pkg.sv
// hilo_ctrl_pkg: funct codes, divider idle signal and FSM state encoding shared by hilo_ctrl
package hilo_ctrl_pkg;
    localparam logic [5:0] DIVU = 6'd27;
    localparam logic [5:0] MFHI = 6'd16;
    localparam logic [5:0] MTHI = 6'd17;
    localparam logic [5:0] MFLO = 6'd18;
    localparam logic [5:0] MTLO = 6'd19;
    localparam logic [5:0] IDLE_SIG = 6'b111111;
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, CAPTURE = 2'd2} state_e;
endpackage

// File: rtl/hilo_ctrl_if.sv
// hilo_ctrl_if: ID/EX instruction inputs, divider link and HI/LO results of hilo_ctrl
// slave: hilo_ctrl side; master: pipeline/divider side
interface hilo_ctrl_if;
    logic        op_valid;
    logic [5:0]  funct;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [63:0] div_result;
    logic [5:0]  div_signal;
    logic [31:0] div_a;
    logic [31:0] div_b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] rd_data;
    logic        stall;
    modport slave (
        input  op_valid, funct, rs_data, rt_data, div_result,
        output div_signal, div_a, div_b, hi, lo, rd_data, stall
    );
    modport master (
        output op_valid, funct, rs_data, rt_data, div_result,
        input  div_signal, div_a, div_b, hi, lo, rd_data, stall
    );
endinterface

// File: rtl/hilo_ctrl.sv
// hilo_ctrl: sequences the iterative divider and owns the HI/LO registers for DIVU/MFHI/MFLO/MTHI/MTLO
// clk, reset (sync, active-high); bus: instruction inputs, divider Signal/operands/result, hi/lo/rd_data/stall
module hilo_ctrl
    import hilo_ctrl_pkg::*;
#(
    parameter int DIV_CYCLES = 32
) (
    input  logic        clk,
    input  logic        reset,
    hilo_ctrl_if.slave  bus
);
    localparam int CNT_W = $clog2(DIV_CYCLES) + 1;
    state_e             state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [31:0]        hi_q, hi_d, lo_q, lo_d, a_q, a_d, b_q, b_d;
    logic               hilo_op;
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        a_d     = a_q;
        b_d     = b_q;
        hilo_op = bus.op_valid && (bus.funct inside {DIVU, MFHI, MTHI, MFLO, MTLO});
        case (state_q)
            IDLE: begin
                if (bus.op_valid && bus.funct == DIVU && bus.rt_data != '0) begin
                    a_d     = bus.rs_data;
                    b_d     = bus.rt_data;
                    count_d = '0;
                    state_d = RUN;
                end else if (bus.op_valid && bus.funct == DIVU) begin
                    // Divide by zero bypasses the divider entirely
                    hi_d = bus.rs_data;
                    lo_d = '1;
                end else if (bus.op_valid && bus.funct == MTHI) begin
                    hi_d = bus.rs_data;
                end else if (bus.op_valid && bus.funct == MTLO) begin
                    lo_d = bus.rs_data;
                end
            end
            RUN: begin
                count_d = count_q + 1'b1;
                state_d = (count_q == CNT_W'(DIV_CYCLES - 1)) ? CAPTURE : RUN;
            end
            CAPTURE: begin
                hi_d    = bus.div_result[63:32];
                lo_d    = bus.div_result[31:0];
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            count_q <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            a_q     <= a_d;
            b_q     <= b_d;
        end
    end
    assign bus.div_signal = (state_q == RUN) ? DIVU : IDLE_SIG;
    assign bus.div_a      = a_q;
    assign bus.div_b      = b_q;
    assign bus.hi         = hi_q;
    assign bus.lo         = lo_q;
    assign bus.rd_data    = (bus.funct == MFHI) ? hi_q : (bus.funct == MFLO) ? lo_q : '0;
    assign bus.stall      = (state_q != IDLE) && hilo_op;
endmodule

// File: tb/tb_hilo_ctrl.sv
// tb_hilo_ctrl: directed scoreboard bench for hilo_ctrl driving a restoring-divider model
module tb_hilo_ctrl;
    logic clk;
    logic reset;
    hilo_ctrl_if bus();
    hilo_ctrl dut (.clk(clk), .reset(reset), .bus(bus.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    logic [63:0] exp_q[$];

    logic [31:0] d_rem, d_quo;
    logic [5:0]  d_step;

    function automatic logic [63:0] div_step(logic [31:0] r_in, logic [31:0] q_in, logic [31:0] b);
        logic [32:0] r;
        logic [31:0] q;
        r = {r_in, q_in[31]};
        q = {q_in[30:0], 1'b0};
        if (r >= {1'b0, b}) begin
            r = r - {1'b0, b};
            q[0] = 1'b1;
        end
        return {r[31:0], q};
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            d_rem  <= '0;
            d_quo  <= '0;
            d_step <= '0;
        end else if (bus.div_signal == 6'd27) begin
            {d_rem, d_quo} <= div_step(d_step == 0 ? 32'd0 : d_rem, d_step == 0 ? bus.div_a : d_quo, bus.div_b);
            d_step <= d_step + 1'b1;
        end else begin
            d_step <= '0;
        end
    end
    assign bus.div_result = {d_rem, d_quo};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic present(input logic v, input logic [5:0] f, input logic [31:0] rs, input logic [31:0] rt);
        bus.op_valid = v;
        bus.funct    = f;
        bus.rs_data  = rs;
        bus.rt_data  = rt;
        #1;
    endtask

    task automatic check_pop(input string tag);
        logic [63:0] e;
        if (exp_q.size() == 0) begin
            chk({tag, "_sb_empty"}, 64'(exp_q.size()), 64'd1);
        end else begin
            e = exp_q.pop_front();
            chk(tag, {bus.hi, bus.lo}, e);
        end
    endtask

    task automatic do_div(input string tag, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] prev;
        int n;
        present(1'b1, 6'd27, a, b);
        chk({tag, "_accept_stall"}, 64'(bus.stall), 64'd0);
        exp_q.push_back(b == 0 ? {a, 32'hFFFF_FFFF} : {a % b, a / b});
        prev = {bus.hi, bus.lo};
        tick();
        present(1'b0, 6'd27, ~a, ~b);
        if (b == 0) begin
            check_pop(tag);
            chk({tag, "_sig_idle"}, 64'(bus.div_signal), 64'h3F);
        end else begin
            n = 0;
            for (int k = 0; k < 32; k++) begin
                if (bus.div_signal == 6'd27) n++;
                tick();
            end
            chk({tag, "_sig_len"}, 64'(n), 64'd32);
            chk({tag, "_capture_sig"}, 64'(bus.div_signal), 64'h3F);
            chk({tag, "_no_early"}, {bus.hi, bus.lo}, prev);
            chk({tag, "_ops_held"}, {bus.div_a, bus.div_b}, {a, b});
            tick();
            check_pop(tag);
        end
    endtask

    initial begin
        int n;
        reset = 1'b1;
        present(1'b0, 6'd0, 32'd0, 32'd0);
        tick();
        tick();
        chk("rst_hilo", {bus.hi, bus.lo}, 64'd0);
        chk("rst_ops", {bus.div_a, bus.div_b}, 64'd0);
        chk("rst_sig", 64'(bus.div_signal), 64'h3F);
        reset = 1'b0;
        present(1'b1, 6'd16, 32'd0, 32'd0);
        chk("rst_stall", 64'(bus.stall), 64'd0);

        do_div("div_100_7", 32'd100, 32'd7);
        present(1'b1, 6'd18, 32'd0, 32'd0);
        chk("mflo_14", 64'(bus.rd_data), 64'd14);
        present(1'b1, 6'd16, 32'd0, 32'd0);
        chk("mfhi_2", 64'(bus.rd_data), 64'd2);

        do_div("div_max_1", 32'hFFFF_FFFF, 32'd1);

        do_div("div_55_0", 32'd55, 32'd0);
        present(1'b1, 6'd16, 32'd0, 32'd0);
        chk("div0_stall", 64'(bus.stall), 64'd0);
        chk("div0_mfhi", 64'(bus.rd_data), 64'd55);

        present(1'b1, 6'd27, 32'd9, 32'd2);
        chk("div9_accept_stall", 64'(bus.stall), 64'd0);
        exp_q.push_back({32'd1, 32'd4});
        tick();
        present(1'b0, 6'd0, 32'd0, 32'd0);
        for (int k = 0; k < 4; k++) tick();
        present(1'b1, 6'd32, 32'd0, 32'd0);
        chk("add_no_stall", 64'(bus.stall), 64'd0);
        present(1'b1, 6'd16, 32'd0, 32'd0);
        n = 0;
        while (bus.stall && n < 40) begin
            n++;
            tick();
        end
        chk("mfhi_stall_len", 64'(n), 64'd29);
        chk("mfhi_fresh", 64'(bus.rd_data), 64'd1);
        check_pop("div_9_2");

        present(1'b1, 6'd19, 32'hDEAD_BEEF, 32'd0);
        tick();
        present(1'b1, 6'd18, 32'd0, 32'd0);
        chk("mtlo_mflo", 64'(bus.rd_data), 64'hDEAD_BEEF);
        chk("mtlo_hi_kept", 64'(bus.hi), 64'd1);
        present(1'b1, 6'd17, 32'h1234_5678, 32'd0);
        tick();
        chk("mthi", 64'(bus.hi), 64'h1234_5678);
        present(1'b0, 6'd17, 32'hAAAA_AAAA, 32'd0);
        tick();
        present(1'b1, 6'd33, 32'h5555_5555, 32'd0);
        tick();
        chk("ignored_ops", {bus.hi, bus.lo}, {32'h1234_5678, 32'hDEAD_BEEF});

        present(1'b1, 6'd27, 32'd50, 32'd6);
        chk("b2b_first_accept", 64'(bus.stall), 64'd0);
        exp_q.push_back({32'd2, 32'd8});
        tick();
        present(1'b1, 6'd27, 32'd7, 32'd3);
        n = 0;
        while (bus.stall && n < 40) begin
            n++;
            tick();
        end
        chk("b2b_stall_len", 64'(n), 64'd33);
        check_pop("b2b_first");
        do_div("b2b_second", 32'd7, 32'd3);

        present(1'b1, 6'd27, 32'd100, 32'd7);
        exp_q.push_back({32'd2, 32'd14});
        tick();
        present(1'b0, 6'd0, 32'd0, 32'd0);
        for (int k = 0; k < 9; k++) tick();
        reset = 1'b1;
        tick();
        exp_q.delete();
        chk("midrst_hilo", {bus.hi, bus.lo}, 64'd0);
        chk("midrst_sig", 64'(bus.div_signal), 64'h3F);
        reset = 1'b0;
        present(1'b1, 6'd16, 32'd0, 32'd0);
        chk("midrst_idle", 64'(bus.stall), 64'd0);
        do_div("div_20_3", 32'd20, 32'd3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
